lse_sequencer: RTL and testbench

//  Parametrised WAIT->LOAD->EXE->STORE control sequencer. Successor to the fixed
//  one-cycle-per-state cyclic FSM. Adds per-state dwell counts, a start/ready

---
 rtl/lse_sequencer.sv | 81 ++++++++
 tb/tb_lse_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lse_sequencer.sv
// lse_sequencer: WAIT->LOAD->EXE->STORE control sequencer with per-state dwell, start/ready handshake, stall, abort, chaining and op counter
module lse_sequencer #(
    parameter int LOAD_CYC  = 1,
    parameter int EXE_CYC   = 2,
    parameter int STORE_CYC = 1,
    parameter int CHAIN     = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic             start,
    output logic             start_ready,
    input  logic             stall,
    input  logic             abort,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] WAIT  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] EXE   = 2'd3;
    localparam int MAX_LE  = LOAD_CYC > EXE_CYC ? LOAD_CYC : EXE_CYC;
    localparam int MAX_CYC = MAX_LE > STORE_CYC ? MAX_LE : STORE_CYC;
    localparam int DW = $clog2(MAX_CYC + 1);
    localparam logic [DW-1:0] LOAD_LAST  = DW'(LOAD_CYC - 1);
    localparam logic [DW-1:0] EXE_LAST   = DW'(EXE_CYC - 1);
    localparam logic [DW-1:0] STORE_LAST = DW'(STORE_CYC - 1);

    if (LOAD_CYC < 1 || EXE_CYC < 1 || STORE_CYC < 1) begin : g_bad_cyc
        $error("lse_sequencer: LOAD_CYC, EXE_CYC and STORE_CYC must all be >= 1");
    end

    logic [DW-1:0] dwell;
    logic          last;
    logic [1:0]    nxt;

    // last cycle of the current state's dwell; WAIT has no dwell
    always_comb
        last = state == LOAD  ? dwell == LOAD_LAST :
               state == EXE   ? dwell == EXE_LAST  :
               state == STORE ? dwell == STORE_LAST : 1'b0;

    assign start_ready = !abort & ((state == WAIT) | ((CHAIN != 0) & (state == STORE) & last & !stall));
    assign busy        = state != WAIT;

    // unstalled, unaborted next state
    always_comb begin
        nxt = state;
        case (state)
            WAIT:    nxt = start ? LOAD : WAIT;
            LOAD:    nxt = last ? EXE : LOAD;
            EXE:     nxt = last ? STORE : EXE;
            STORE:   nxt = !last ? STORE : (start & start_ready) ? LOAD : WAIT;
            default: nxt = WAIT;
        endcase
    end

    // state, dwell, done pulse and completed-op count; abort beats stall, and stall never blocks WAIT
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state    <= WAIT;
            dwell    <= '0;
            done     <= 1'b0;
            op_count <= '0;
        end else if (abort) begin
            state <= WAIT;
            dwell <= '0;
            done  <= 1'b0;
        end else if (stall && state != WAIT) begin
            done <= 1'b0;
        end else begin
            state <= nxt;
            dwell <= (nxt != state || state == WAIT) ? '0 : dwell + 1'b1;
            done  <= state == STORE && last;
            if (state == STORE && last)
                op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_lse_sequencer.sv
// tb_lse_sequencer: randomized check of lse_sequencer against an op-position reference model
module tb_lse_sequencer;
    localparam int L = 1;
    localparam int E = 2;
    localparam int S = 1;
    localparam int T = L + E + S;

    logic       clk = 1'b0, rstx = 1'b0, start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic       rdy0, rdy1, busy0, busy1, done0, done1;
    logic [1:0] st0, st1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    int errors = 0, checks = 0;
    int pos[2];
    int cnt[2];
    bit dn[2];
    int seq[4] = '{3, 3, 2, 0};

    always #5 clk = ~clk;

    lse_sequencer u0 (
        .clk(clk), .rstx(rstx), .start(start), .start_ready(rdy0), .stall(stall), .abort(abort),
        .state(st0), .busy(busy0), .done(done0), .op_count(cnt0)
    );

    lse_sequencer #(.CHAIN(1), .CNT_W(2)) u1 (
        .clk(clk), .rstx(rstx), .start(start), .start_ready(rdy1), .stall(stall), .abort(abort),
        .state(st1), .busy(busy1), .done(done1), .op_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // pos is the cycle index within the running op, -1 when idle
    function automatic int exp_state(input int p);
        return p < 0 ? 0 : p < L ? 1 : p < L + E ? 3 : 2;
    endfunction

    function automatic bit exp_ready(input int k);
        return !abort && (pos[k] < 0 || (k == 1 && pos[k] == T - 1 && !stall));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = -1;
            cnt[k] = 0;
            dn[k]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int k);
        dn[k] = 1'b0;
        if (abort) pos[k] = -1;
        else if (stall && pos[k] >= 0) pos[k] = pos[k];
        else if (pos[k] < 0) pos[k] = start ? 0 : -1;
        else if (pos[k] == T - 1) begin
            dn[k]  = 1'b1;
            cnt[k] = (cnt[k] + 1) % (k == 1 ? 4 : 256);
            pos[k] = (k == 1 && start) ? 0 : -1;
        end else pos[k] = pos[k] + 1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".st0"},   32'(st0),   32'(exp_state(pos[0])));
        chk({tag, ".busy0"}, 32'(busy0), 32'(pos[0] >= 0));
        chk({tag, ".done0"}, 32'(done0), 32'(dn[0]));
        chk({tag, ".cnt0"},  32'(cnt0),  32'(cnt[0]));
        chk({tag, ".st1"},   32'(st1),   32'(exp_state(pos[1])));
        chk({tag, ".busy1"}, 32'(busy1), 32'(pos[1] >= 0));
        chk({tag, ".done1"}, 32'(done1), 32'(dn[1]));
        chk({tag, ".cnt1"},  32'(cnt1),  32'(cnt[1]));
    endtask

    task automatic tick(input bit s, input bit st, input bit ab);
        start = s;
        stall = st;
        abort = ab;
        #1;
        chk("rdy0", 32'(rdy0), 32'(exp_ready(0)));
        chk("rdy1", 32'(rdy1), 32'(exp_ready(1)));
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_out("cyc");
    endtask

    initial begin
        model_reset();
        #3;
        check_out("rst_pre_edge");
        @(posedge clk);
        #1;
        check_out("rst_held");
        rstx = 1'b1;
        // single op, defaults
        tick(1, 0, 0);
        chk("t1.load", 32'(st0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            chk("t1.seq", 32'(st0), 32'(seq[i]));
            chk("t1.done", 32'(done0), 32'(i == 3));
        end
        chk("t1.cnt", 32'(cnt0), 32'd1);
        // start held: u1 chains back to back, u0 returns to WAIT between ops
        repeat (12) tick(1, 0, 0);
        repeat (6) tick(0, 0, 0);
        // stall mid-EXE
        tick(1, 0, 0);
        tick(0, 0, 0);
        repeat (3) tick(0, 1, 0);
        repeat (6) tick(0, 0, 0);
        // abort in EXE with start asserted
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 1);
        chk("t4.st", 32'(st0), 32'd0);
        chk("t4.done", 32'(done0), 32'd0);
        repeat (3) tick(0, 0, 0);
        // enough ops to wrap the 2-bit counter
        repeat (5) begin
            tick(1, 0, 0);
            repeat (4) tick(0, 0, 0);
        end
        // async reset mid-STORE, between edges
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("t6.in_store", 32'(st0), 32'd2);
        #2 rstx = 1'b0;
        model_reset();
        #1;
        chk("t6.async_st", 32'(st0), 32'd0);
        chk("t6.async_done", 32'(done0), 32'd0);
        check_out("t6");
        @(negedge clk);
        rstx = 1'b1;
        // async reset while done is high
        tick(1, 0, 0);
        repeat (4) tick(0, 0, 0);
        chk("t6b.done_hi", 32'(done0), 32'd1);
        #2 rstx = 1'b0;
        model_reset();
        #1;
        check_out("t6b");
        @(negedge clk);
        rstx = 1'b1;
        // random traffic
        repeat (400)
            tick($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
